// File: rtl/dsi_pkg.sv
// dsi_pkg: shared state encoding, byte constants and default timings for the DSI lane-0 HS sequencer
// Optional EoTp state is present only when DSI_HS_EOTP_EN is defined.
package dsi_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA,
`ifdef DSI_HS_EOTP_EN
    ST_EOTP,
`endif
    ST_TRAIL, ST_EXIT
  } state_t;
  localparam logic [7:0] DSI_SYNC_BYTE = 8'hB8;
  localparam logic [7:0] DSI_EOTP_0 = 8'h08;
  localparam logic [7:0] DSI_EOTP_1 = 8'h0F;
  localparam logic [7:0] DSI_EOTP_2 = 8'h0F;
  localparam logic [7:0] DSI_EOTP_3 = 8'h01;
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [7:0] DEF_T_LPX = 8'd8;
  localparam logic [7:0] DEF_T_HS_PREP = 8'd6;
  localparam logic [7:0] DEF_T_HS_ZERO = 8'd16;
  localparam logic [7:0] DEF_T_HS_TRAIL = 8'd10;
  localparam logic [7:0] DEF_T_HS_EXIT = 8'd12;
  function automatic logic [7:0] trail_of(input logic [7:0] b);
    return b[7] ? 8'h00 : 8'hFF;
  endfunction
endpackage

// File: rtl/dsi_lp_timer.sv
// dsi_lp_timer: loadable 8-bit down-counter, load of 0 clamps to 1, never decrements below 1
// Ports: clk, rst_n (async active-low), i_load/i_val load request and value, o_done high while count is 1.
module dsi_lp_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_done
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= (i_val == 8'd0) ? 8'd1 : i_val;
    else if (r_cnt > 8'd1) r_cnt <= r_cnt - 8'd1;
  assign o_done = (r_cnt == 8'd1);
endmodule

// File: rtl/dsi_d0_hs_seq.sv
// dsi_d0_hs_seq: MIPI DSI data-lane-0 HS burst sequencer (SoT, packet stream, HS-trail, LP-11 exit)
// Ports: clk/rst_n (async active-low); lcm_init_done, burst_req gate and request bursts;
// pkt_vld/pkt_data/pkt_last/pkt_rdy upstream byte handshake; lp_d0_p/lp_d0_n LP pins;
// hs_oe/hs_byte HS serializer; burst_busy, underflow_err status. All outputs registered.
// Define DSI_HS_EOTP_EN to append the EoTp bytes 08 0F 0F 01 after the last packet byte.
module dsi_d0_hs_seq
  import dsi_pkg::*;
#(
  parameter logic [7:0] T_LPX      = DEF_T_LPX,
  parameter logic [7:0] T_HS_PREP  = DEF_T_HS_PREP,
  parameter logic [7:0] T_HS_ZERO  = DEF_T_HS_ZERO,
  parameter logic [7:0] T_HS_TRAIL = DEF_T_HS_TRAIL,
  parameter logic [7:0] T_HS_EXIT  = DEF_T_HS_EXIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcm_init_done,
  input  logic       burst_req,
  input  logic       pkt_vld,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  output logic       pkt_rdy,
  output logic       lp_d0_p,
  output logic       lp_d0_n,
  output logic       hs_oe,
  output logic [7:0] hs_byte,
  output logic       burst_busy,
  output logic       underflow_err
);
  state_t     r_state, w_nxt;
  logic [1:0] r_lp, w_lp_nxt;
  logic [7:0] r_hs_byte, w_hs_nxt, w_ld_val;
  logic       r_hs_oe, r_pkt_rdy, r_busy, r_uf, r_fin;
  logic       w_done, w_acc, w_fin_nxt, w_end;
`ifdef DSI_HS_EOTP_EN
  logic [1:0] r_eot;
`endif
  assign w_acc = r_pkt_rdy & pkt_vld;
  assign w_fin_nxt = r_fin | (w_acc & pkt_last);
  // DATA ends once the last byte has been shown, or immediately when upstream starves
  assign w_end = r_fin | ~pkt_vld;
  dsi_lp_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_nxt != r_state),
    .i_val  (w_ld_val),
    .o_done (w_done)
  );
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_nxt = (lcm_init_done && burst_req) ? ST_LPX : ST_IDLE;
      ST_LPX:   if (w_done) w_nxt = ST_PREP;
      ST_PREP:  if (w_done) w_nxt = ST_ZERO;
      ST_ZERO:  if (w_done) w_nxt = ST_SYNC;
      ST_SYNC:  w_nxt = ST_DATA;
`ifdef DSI_HS_EOTP_EN
      ST_DATA:  if (w_end) w_nxt = ST_EOTP;
      ST_EOTP:  if (r_eot == 2'd3) w_nxt = ST_TRAIL;
`else
      ST_DATA:  if (w_end) w_nxt = ST_TRAIL;
`endif
      ST_TRAIL: if (w_done) w_nxt = ST_EXIT;
      ST_EXIT:  if (w_done) w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end
  assign w_ld_val = (w_nxt == ST_LPX)   ? T_LPX :
                    (w_nxt == ST_PREP)  ? T_HS_PREP :
                    (w_nxt == ST_ZERO)  ? T_HS_ZERO :
                    (w_nxt == ST_TRAIL) ? T_HS_TRAIL :
                    (w_nxt == ST_EXIT)  ? T_HS_EXIT : 8'd1;
  assign w_lp_nxt = (w_nxt == ST_IDLE || w_nxt == ST_EXIT) ? LP11 :
                    (w_nxt == ST_LPX) ? LP01 : LP00;
  // Trail byte is derived from whatever byte is on the lane when TRAIL is entered, then held
  always_comb begin
    w_hs_nxt = 8'h00;
    if (w_acc) w_hs_nxt = pkt_data;
    else if (w_nxt == ST_SYNC) w_hs_nxt = DSI_SYNC_BYTE;
    else if (w_nxt == ST_TRAIL) w_hs_nxt = (r_state == ST_TRAIL) ? r_hs_byte : trail_of(r_hs_byte);
`ifdef DSI_HS_EOTP_EN
    else if (w_nxt == ST_EOTP) w_hs_nxt = (r_state != ST_EOTP) ? DSI_EOTP_0 :
                                          (r_eot == 2'd2) ? DSI_EOTP_3 :
                                          (r_eot == 2'd1) ? DSI_EOTP_2 : DSI_EOTP_1;
`endif
    else if (w_nxt == ST_DATA) w_hs_nxt = r_hs_byte;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lp      <= LP11;
      r_hs_oe   <= 1'b0;
      r_hs_byte <= 8'h00;
      r_pkt_rdy <= 1'b0;
      r_busy    <= 1'b0;
      r_uf      <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_lp      <= w_lp_nxt;
      r_hs_oe   <= (w_lp_nxt == LP00) && (w_nxt != ST_PREP);
      r_hs_byte <= w_hs_nxt;
      r_pkt_rdy <= (w_nxt == ST_SYNC) || ((w_nxt == ST_DATA) && !w_fin_nxt);
      r_busy    <= (w_nxt != ST_IDLE);
      r_uf      <= (r_state == ST_DATA) && !r_fin && !pkt_vld;
      r_fin     <= (w_nxt == ST_DATA) && w_fin_nxt;
    end
`ifdef DSI_HS_EOTP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_eot <= 2'd0;
    else r_eot <= (r_state == ST_EOTP) ? r_eot + 2'd1 : 2'd0;
`endif
  assign pkt_rdy       = r_pkt_rdy;
  assign lp_d0_p       = r_lp[1];
  assign lp_d0_n       = r_lp[0];
  assign hs_oe         = r_hs_oe;
  assign hs_byte       = r_hs_byte;
  assign burst_busy    = r_busy;
  assign underflow_err = r_uf;
endmodule

// File: tb/tb_dsi_d0_hs_seq.sv
// tb_dsi_d0_hs_seq: scoreboard bench for dsi_d0_hs_seq; expected lane rows are queued per burst and popped each cycle
module tb_dsi_d0_hs_seq;
  typedef logic [7:0] bq_t[$];
  localparam logic [13:0] RST_ROW = {2'b11, 1'b0, 8'h00, 3'b000};
  logic       clk = 1'b0;
  logic       rst_n, lcm_init_done, burst_req, pkt_vld, pkt_last;
  logic [7:0] pkt_data;
  logic       pkt_rdy, lp_d0_p, lp_d0_n, hs_oe, burst_busy, underflow_err;
  logic [7:0] hs_byte;
  logic       u1_rdy, u1_p, u1_n, u1_oe, u1_busy, u1_uf;
  logic [7:0] u1_byte;
  logic [13:0] obs;
  logic [13:0] exp_q[$];
  logic [8:0]  src_q[$];
  bq_t         bq;
  int          n_chk = 0, n_fail = 0, s3, len4;
  bit          acc = 1'b0;
  dsi_d0_hs_seq u_dut (
    .clk(clk), .rst_n(rst_n), .lcm_init_done(lcm_init_done), .burst_req(burst_req),
    .pkt_vld(pkt_vld), .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_rdy(pkt_rdy),
    .lp_d0_p(lp_d0_p), .lp_d0_n(lp_d0_n), .hs_oe(hs_oe), .hs_byte(hs_byte),
    .burst_busy(burst_busy), .underflow_err(underflow_err)
  );
  dsi_d0_hs_seq #(.T_LPX(8'd0)) u_lpx0 (
    .clk(clk), .rst_n(rst_n), .lcm_init_done(lcm_init_done), .burst_req(burst_req),
    .pkt_vld(1'b0), .pkt_data(8'h00), .pkt_last(1'b0), .pkt_rdy(u1_rdy),
    .lp_d0_p(u1_p), .lp_d0_n(u1_n), .hs_oe(u1_oe), .hs_byte(u1_byte),
    .burst_busy(u1_busy), .underflow_err(u1_uf)
  );
  always #5 clk = ~clk;
  assign obs = {lp_d0_p, lp_d0_n, hs_oe, hs_byte, burst_busy, underflow_err, pkt_rdy};
  task automatic push(input logic [1:0] lp, input logic oe, input logic [7:0] b,
                      input logic busy, input logic uf, input logic rdy, input int n);
    repeat (n) exp_q.push_back({lp, oe, b, busy, uf, rdy});
  endtask
  task automatic burst(input bq_t b, input bit uf);
    int n;
    logic [7:0] lastb;
    bit first;
    n = b.size();
    first = 1'b1;
    foreach (b[i]) src_q.push_back({(i == n - 1) && !uf, b[i]});
    push(2'b01, 0, 8'h00, 1, 0, 0, 8);
    push(2'b00, 0, 8'h00, 1, 0, 0, 6);
    push(2'b00, 1, 8'h00, 1, 0, 0, 16);
    push(2'b00, 1, 8'hB8, 1, 0, 1, 1);
    foreach (b[i]) push(2'b00, 1, b[i], 1, 0, uf || (i < n - 1), 1);
    lastb = b[n - 1];
`ifdef DSI_HS_EOTP_EN
    bq = '{8'h08, 8'h0F, 8'h0F, 8'h01};
    foreach (bq[i]) begin
      push(2'b00, 1, bq[i], 1, uf && first, 0, 1);
      first = 1'b0;
    end
    lastb = 8'h01;
`endif
    push(2'b00, 1, lastb[7] ? 8'h00 : 8'hFF, 1, uf && first, 0, 1);
    push(2'b00, 1, lastb[7] ? 8'h00 : 8'hFF, 1, 0, 0, 9);
    push(2'b11, 0, 8'h00, 1, 0, 0, 12);
    push(2'b11, 0, 8'h00, 0, 0, 0, 1);
  endtask
  task automatic cyc();
    logic [13:0] e;
    @(posedge clk);
    if (acc) void'(src_q.pop_front());
    @(negedge clk);
    pkt_vld = src_q.size() > 0;
    {pkt_last, pkt_data} = pkt_vld ? src_q[0] : 9'h000;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL stream[%0d] {lp,oe,byte,busy,uf,rdy}: observed %h expected %h", n_chk, obs, e);
      end
    end
    acc = pkt_rdy && pkt_vld;
  endtask
  task automatic run(input int keep);
    for (int i = 0; i < 3000 && exp_q.size() > keep; i++) cyc();
    n_chk++;
    assert (exp_q.size() <= keep) else begin
      n_fail++;
      $error("FAIL run_timeout: observed %0d pending rows expected %0d", exp_q.size(), keep);
    end
  endtask
  initial begin
    rst_n = 1'b1;
    lcm_init_done = 1'b0;
    burst_req = 1'b0;
    pkt_vld = 1'b0;
    pkt_last = 1'b0;
    pkt_data = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    n_chk++;
    assert (obs === RST_ROW) else begin
      n_fail++;
      $error("FAIL reset_values: observed %h expected %h", obs, RST_ROW);
    end
    @(negedge clk);
    rst_n = 1'b1;
    burst_req = 1'b1;
    push(2'b11, 0, 8'h00, 0, 0, 0, 500);
    run(0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h84};
    burst(bq, 1'b0);
    lcm_init_done = 1'b1;
    cyc();
    burst_req = 1'b0;
    n_chk++;
    assert ({u1_p, u1_n} === 2'b01) else begin
      n_fail++;
      $error("FAIL lpx0_first: observed %b expected 01", {u1_p, u1_n});
    end
    cyc();
    n_chk++;
    assert ({u1_p, u1_n} === 2'b00) else begin
      n_fail++;
      $error("FAIL lpx0_second: observed %b expected 00", {u1_p, u1_n});
    end
    lcm_init_done = 1'b0;
    run(0);
    lcm_init_done = 1'b1;
    bq = '{8'h55, 8'h7F};
    burst(bq, 1'b0);
    s3 = exp_q.size();
    bq = '{8'h11, 8'h22};
    burst(bq, 1'b1);
    len4 = exp_q.size() - s3;
    burst_req = 1'b1;
    run(len4 - 1);
    burst_req = 1'b0;
    run(0);
    bq = '{8'hAA, 8'h81};
    burst(bq, 1'b0);
    burst_req = 1'b1;
    cyc();
    burst_req = 1'b0;
    repeat (17) cyc();
    rst_n = 1'b0;
    #1;
    n_chk++;
    assert (obs === RST_ROW) else begin
      n_fail++;
      $error("FAIL reset_in_zero: observed %h expected %h", obs, RST_ROW);
    end
    exp_q.delete();
    src_q.delete();
    acc = 1'b0;
    pkt_vld = 1'b0;
    pkt_last = 1'b0;
    pkt_data = 8'h00;
    rst_n = 1'b1;
    burst(bq, 1'b0);
    burst_req = 1'b1;
    cyc();
    burst_req = 1'b0;
    run(0);
    bq = '{8'h80};
    burst(bq, 1'b0);
    burst_req = 1'b1;
    cyc();
    burst_req = 1'b0;
    run(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
